// File: rtl/riscv_mc_sequencer_if.sv
// Sequencer <-> datapath/memory handshake bundle: IMEM and DMEM req/ready pairs,
// the state-changing strobes, and the ROM control word in and out.
interface riscv_mc_sequencer_if #(
  parameter int CTRL_W = 20
);
  logic              if_req;
  logic              if_ready;
  logic              ir_we;
  logic              pc_we;
  logic              mem_req;
  logic              mem_ready;
  logic              mem_we;
  logic              reg_we;
  logic [CTRL_W-1:0] rom_data;
  logic [CTRL_W-1:0] ctrl_out;

  modport master (
    output if_req, ir_we, pc_we, mem_req, mem_we, reg_we, ctrl_out,
    input  if_ready, mem_ready, rom_data
  );

  modport slave (
    input  if_req, ir_we, pc_we, mem_req, mem_we, reg_we, ctrl_out,
    output if_ready, mem_ready, rom_data
  );
endinterface

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles (5 for load/store) plus
// one per IMEM/DMEM wait cycle; if_ready/mem_ready low stalls in FETCH/MEM with requests held.
module riscv_mc_sequencer #(
  parameter int CNT_W  = 32,
  parameter int CTRL_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  riscv_mc_sequencer_if.master bus,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam int REGWEN_BIT = 15;
  localparam int MEMRW_BIT  = 7;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              regwen_q, regwen_d;
  logic              memrw_q, memrw_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    regwen_d  = regwen_q;
    memrw_d   = memrw_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;

    case (state_q)
      S_FETCH: begin
        if (run && bus.if_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Strobe enables live in their own flops so ctrl_out never carries them.
        ctrl_d             = bus.rom_data;
        ctrl_d[REGWEN_BIT] = 1'b0;
        ctrl_d[MEMRW_BIT]  = 1'b0;
        regwen_d           = bus.rom_data[REGWEN_BIT];
        memrw_d            = bus.rom_data[MEMRW_BIT];
        state_d            = S_EXEC;
      end
      S_EXEC: begin
        state_d = (memrw_q || (ctrl_q[1:0] == 2'b00)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = S_WB;
      end
      S_WB: begin
        instret_d = instret_q + 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (run || (state_q != S_FETCH)) cycle_d = cycle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= '0;
      regwen_q  <= 1'b0;
      memrw_q   <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      regwen_q  <= regwen_d;
      memrw_q   <= memrw_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // The fetch request follows run directly; rst_n gates it so nothing is requested in reset.
  always_comb begin
    bus.if_req  = rst_n && run && (state_q == S_FETCH);
    bus.ir_we   = bus.if_req && bus.if_ready;
    bus.mem_req = (state_q == S_MEM);
    bus.mem_we  = (state_q == S_MEM) && memrw_q;
    bus.reg_we  = (state_q == S_WB) && regwen_q;
    bus.pc_we   = (state_q == S_WB);
  end

  assign bus.ctrl_out = ctrl_q;
  assign state        = state_q;
  assign cycle_cnt    = cycle_q;
  assign instret_cnt  = instret_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Directed bench for riscv_mc_sequencer: ALU, store with DMEM waits, load, branch,
// run drop, async reset mid-MEM, and counter wrap on a narrow-counter instance.
module tb_riscv_mc_sequencer;

  localparam logic [19:0] ADD_W = 20'h08001;
  localparam logic [19:0] SW_W  = 20'h12081;
  localparam logic [19:0] LW_W  = 20'h0A000;
  localparam logic [19:0] BEQ_W = 20'hA3001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [2:0]  state, state_w;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [1:0]  cycle_w, instret_w;
  int          checks = 0;
  int          errors = 0;
  int          writes;

  riscv_mc_sequencer_if #(.CTRL_W(20)) bus ();
  riscv_mc_sequencer_if #(.CTRL_W(20)) bw ();

  assign bw.if_ready  = bus.if_ready;
  assign bw.mem_ready = bus.mem_ready;
  assign bw.rom_data  = bus.rom_data;

  riscv_mc_sequencer #(.CNT_W(32), .CTRL_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .bus(bus),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  riscv_mc_sequencer #(.CNT_W(2), .CTRL_W(20)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run), .bus(bw),
    .state(state_w), .cycle_cnt(cycle_w), .instret_cnt(instret_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, bus.if_req, bus.ir_we, bus.pc_we, bus.mem_req, bus.mem_we, bus.reg_we},
        {26'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    bus.if_ready = 1'b1;
    bus.mem_ready = 1'b1;
    bus.rom_data = '0;
    #12;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk_strobes("rst_strobes", 6'b000000);
    chk("rst_ctrl", {12'd0, bus.ctrl_out}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);

    // 1: ADD x3,x1,x2
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("add_c1_state", {29'd0, state}, 32'd0);
    chk_strobes("add_c1_strobes", 6'b110000);
    bus.rom_data = ADD_W;
    tick();
    chk("add_c2_state", {29'd0, state}, 32'd1);
    chk_strobes("add_c2_strobes", 6'b000000);
    tick();
    chk("add_c3_state", {29'd0, state}, 32'd2);
    chk("add_c3_ctrl", {12'd0, bus.ctrl_out}, 32'h00001);
    chk_strobes("add_c3_strobes", 6'b000000);
    tick();
    chk("add_c4_state", {29'd0, state}, 32'd4);
    chk_strobes("add_c4_strobes", 6'b001001);
    tick();
    chk("add_instret", instret_cnt, 32'd1);
    chk("add_cycle", cycle_cnt, 32'd4);

    // 2: SW with three DMEM wait cycles
    bus.rom_data = SW_W;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("sw_exec_ctrl", {12'd0, bus.ctrl_out}, 32'h12001);
    tick();
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", {29'd0, state}, 32'd3);
      chk_strobes("sw_wait_strobes", 6'b000110);
      if (bus.mem_req && bus.mem_we && bus.mem_ready) writes++;
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk_strobes("sw_ready_strobes", 6'b000110);
    if (bus.mem_req && bus.mem_we && bus.mem_ready) writes++;
    tick();
    chk("sw_wb_state", {29'd0, state}, 32'd4);
    chk_strobes("sw_wb_strobes", 6'b001000);
    chk("sw_single_write", writes, 32'd1);
    tick();
    chk("sw_instret", instret_cnt, 32'd2);
    chk("sw_cycle", cycle_cnt, 32'd12);

    // 3: LW goes through MEM, reg_we only in WB
    bus.rom_data = LW_W;
    tick();
    tick();
    chk("lw_exec_ctrl", {12'd0, bus.ctrl_out}, 32'h02000);
    tick();
    chk("lw_mem_state", {29'd0, state}, 32'd3);
    chk_strobes("lw_mem_strobes", 6'b000100);
    tick();
    chk_strobes("lw_wb_strobes", 6'b001001);
    tick();
    chk("lw_instret", instret_cnt, 32'd3);
    chk("lw_cycle", cycle_cnt, 32'd17);

    // 4: BEQ taken
    bus.rom_data = BEQ_W;
    tick();
    tick();
    chk("beq_exec_ctrl", {12'd0, bus.ctrl_out}, 32'hA3001);
    chk_strobes("beq_exec_strobes", 6'b000000);
    tick();
    chk("beq_wb_state", {29'd0, state}, 32'd4);
    chk_strobes("beq_wb_strobes", 6'b001000);
    tick();
    chk("beq_instret", instret_cnt, 32'd4);
    chk("beq_cycle", cycle_cnt, 32'd21);
    chk("wrap_instret", {30'd0, instret_w}, 32'd0);
    chk("wrap_cycle", {30'd0, cycle_w}, 32'd1);

    // 5: run dropped in EXEC
    bus.rom_data = ADD_W;
    tick();
    tick();
    run = 1'b0;
    #1;
    chk("rundrop_exec_state", {29'd0, state}, 32'd2);
    tick();
    chk("rundrop_wb_state", {29'd0, state}, 32'd4);
    chk_strobes("rundrop_wb_strobes", 6'b001001);
    tick();
    chk("rundrop_fetch_state", {29'd0, state}, 32'd0);
    chk_strobes("rundrop_idle_strobes", 6'b000000);
    chk("rundrop_cycle", cycle_cnt, 32'd25);
    chk("rundrop_instret", instret_cnt, 32'd5);
    tick();
    tick();
    tick();
    chk("idle_cycle_frozen", cycle_cnt, 32'd25);
    chk("idle_instret_frozen", instret_cnt, 32'd5);
    chk("idle_state", {29'd0, state}, 32'd0);

    // 6: async reset in the middle of a stalled store
    run = 1'b1;
    bus.mem_ready = 1'b0;
    bus.rom_data = SW_W;
    #1;
    chk_strobes("rst6_fetch_strobes", 6'b110000);
    tick();
    tick();
    tick();
    chk_strobes("rst6_mem_strobes", 6'b000110);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst6_state", {29'd0, state}, 32'd0);
    chk_strobes("rst6_strobes", 6'b000000);
    chk("rst6_ctrl", {12'd0, bus.ctrl_out}, 32'd0);
    chk("rst6_cycle", cycle_cnt, 32'd0);
    chk("rst6_instret", instret_cnt, 32'd0);
    tick();
    chk_strobes("rst6_held_strobes", 6'b000000);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
